// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: async assert / sync release, then staged bus -> periph -> cpu release.
// Optional RST_SEQ_CAUSE_EN macro adds the rst_cause register (otherwise rst_cause = 2'b00).
module rst_seq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       async_rst_n,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  output logic       bus_rst_n,
  output logic       periph_rst_n,
  output logic       cpu_rst_n,
  output logic       rst_busy,
  output logic       rst_done,
  output logic [1:0] rst_cause
);

  localparam logic [1:0] ST_HOLD       = 2'd0;
  localparam logic [1:0] ST_REL_BUS    = 2'd1;
  localparam logic [1:0] ST_REL_PERIPH = 2'd2;
  localparam logic [1:0] ST_RUN        = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rst_n;
  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic                   rst_req;

  assign sync_rst_n = sync_q[SYNC_STAGES-1];
  assign rst_req    = sw_rst_req | wdt_rst_req;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Every output is its own flop so releases are glitch-free regardless of state encoding.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state        <= ST_HOLD;
      cnt          <= '0;
      bus_rst_n    <= 1'b0;
      periph_rst_n <= 1'b0;
      cpu_rst_n    <= 1'b0;
      rst_busy     <= 1'b1;
      rst_done     <= 1'b0;
    end else begin
      rst_done <= 1'b0;
      case (state)
        ST_HOLD: begin
          if (sync_rst_n) begin
            if (cnt == HOLD_LAST) begin
              state     <= ST_REL_BUS;
              cnt       <= '0;
              bus_rst_n <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_REL_BUS: begin
          if (cnt == STEP_LAST) begin
            state        <= ST_REL_PERIPH;
            cnt          <= '0;
            periph_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REL_PERIPH: begin
          if (cnt == STEP_LAST) begin
            state     <= ST_RUN;
            cnt       <= '0;
            cpu_rst_n <= 1'b1;
            rst_busy  <= 1'b0;
            rst_done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // Requests are level-sampled; a request still high on return to RUN fires again.
          if (rst_req) begin
            state        <= ST_HOLD;
            cnt          <= '0;
            bus_rst_n    <= 1'b0;
            periph_rst_n <= 1'b0;
            cpu_rst_n    <= 1'b0;
            rst_busy     <= 1'b1;
          end
        end
        default: begin
          state <= ST_HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause_q;

  // Watchdog wins over software when both request on the same edge.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      cause_q <= 2'b01;
    end else if (state == ST_RUN && rst_req) begin
      cause_q <= wdt_rst_req ? 2'b11 : 2'b10;
    end
  end

  assign rst_cause = cause_q;
`else
  assign rst_cause = 2'b00;
`endif

endmodule
